player_sprite_ctrl: RTL and testbench
=====================================

// Module: player_sprite_ctrl
// PURPOSE
//  Parametrised player sprite controller for the 160x120 VGA playfield.
//  Holds the player position and moves it on a rate-divider tick from left/right.
//  Sequences erase-old / draw-new pixel sweeps to the VGA plotter through a valid/ready handshake.
//  Erases the sprite and freezes on got_hit. Sits between the input sync logic and the VGA pixel mux.
// PARAMETERS
//  SPR_W     5       sprite width in pixels (1..16)
//  SPR_H     4       sprite height in pixels (1..16)
//  X_MAX     159     rightmost legal screen column
//  START_X   78      x of sprite top-left after reset; START_X+SPR_W-1 <= X_MAX
//  START_Y   100     y of sprite top-left (fixed; sprite moves in x only)
//  STEP      1       columns moved per accepted tick
//  COLOUR    3'b111  draw colour (erase colour is always 3'b000)
//  COOLDOWN  8       ticks between shots (PLAYER_FIRE_EN only)
// PORTS
//  clk         in   1  system clock
//  reset_n     in   1  reset; one clock; reset is asynchronous and active-high
//  tick        in   1  1-cycle movement strobe from rate divider
//  left        in   1  move-left request, level
//  right       in   1  move-right request, level
//  got_hit     in   1  player shot, 1-cycle pulse or level
//  plot_ready  in   1  VGA plotter accepts current pixel
//  plot        out  1  pixel valid
//  x_pos       out  8  pixel x
//  y_pos       out  7  pixel y
//  colour      out  3  pixel colour
//  busy        out  1  high in any state other than IDLE/DEAD
//  alive       out  1  low once the hit erase has started
//  fire        in   1  fire request, level (PLAYER_FIRE_EN)
//  shot_req    out  1  1-cycle bullet spawn pulse
//  shot_x      out  8  bullet spawn x = x_reg + SPR_W/2
//  shot_y      out  7  bullet spawn y = START_Y - 1
// BEHAVIOUR
//  Reset values: x_reg=START_X, plot=0, x_pos=0, y_pos=0, colour=0, busy=0, alive=1, shot_req=0, cooldown=0, hit_pend=0, state=DRAW.
//  FSM: DRAW, IDLE, ERASE, UPDATE, DEAD.
//   DRAW: sweep the box at x_reg; colour=COLOUR; go to IDLE after the last pixel is accepted.
//   IDLE: if hit_pend or got_hit, go to ERASE with kill=1.
//     Else on tick, with exactly one of left/right high and the move legal, go to ERASE with kill=0.
//     Otherwise stay in IDLE.
//   ERASE: sweep the box at x_reg with colour=000. After the last pixel: kill=1 -> DEAD; kill=0 -> UPDATE.
//   UPDATE: one cycle; x_reg moves by STEP (left: -STEP, right: +STEP) using the direction latched in IDLE; next state DRAW.
//   DEAD: plot=0; stay until reset.
//  Sweep order: row-major, col 0..SPR_W-1 within row 0..SPR_H-1.
//   Pixel address is x_pos = x_reg+col, y_pos = START_Y+row. Each sweep is exactly SPR_W*SPR_H accepted pixels.
//  Handshake: a pixel transfers when plot & plot_ready.
//   While plot & !plot_ready, x_pos/y_pos/colour hold stable. plot never drops mid-sweep.
//   plot rises the cycle after the state is entered.
//  Move legality: left requires x_reg >= STEP; right requires x_reg + STEP + SPR_W - 1 <= X_MAX.
//   An illegal move, or left&right both high, causes no sweep and no x change.
//  Tick outside IDLE is dropped; it is not queued.
//  got_hit during DRAW/ERASE/UPDATE sets hit_pend; the current sweep completes, then IDLE goes to ERASE with kill=1.
//   alive drops on entry to the kill ERASE.
//  All x arithmetic is 8-bit unsigned; the legality checks guarantee no wrap.
//  Asynchronous reset mid-sweep aborts at once and restarts with the DRAW at START_X.
// CONFIGURATION
//  PLAYER_FIRE_EN defined:
//   - A tick with fire=1, cooldown==0 and alive=1 pulses shot_req for 1 cycle and loads cooldown=COOLDOWN.
//   - Each tick decrements a non-zero cooldown. Firing is allowed in any state except DEAD.
//   - shot_x/shot_y are sampled with the pulse.
//  PLAYER_FIRE_EN undefined: fire is ignored; shot_req, shot_x and shot_y are tied 0; no cooldown logic.
// TESTING
//  T1 Reset, plot_ready=1:
//   - 20 pixels at colour 111, x 78..82, y 100..103, row-major, then busy=0.
//  T2 Idle, tick with right=1, plot_ready=1:
//   - 20 erase pixels (000) at x 78..82, then 20 draw pixels (111) at x 79..83. x_reg=79.
//  T3 Bounds:
//   - Drive left until x_reg=0; further left ticks give no plot.
//   - At x_reg=155 a right tick gives no plot.
//   - left&right together give no plot.
//  T4 Backpressure: toggle plot_ready 1/0 each cycle during a sweep.
//   - Outputs stay stable while stalled; exactly 20 transfers per sweep; no skipped or duplicate pixel.
//  T5 Hit: pulse got_hit mid-DRAW.
//   - DRAW finishes, 20 erase pixels follow, then DEAD: alive=0, plot=0.
//   - Later ticks with left or right give no plot.
//  T6 (PLAYER_FIRE_EN) fire held, COOLDOWN=8:
//   - shot_req on tick 1 with shot_x=x_reg+2, shot_y=99; next pulse on tick 10.
//   - No pulse after got_hit.

Source files
------------

// File: rtl/player_sprite_ctrl.sv
// Player sprite controller: moves a SPR_W x SPR_H box along x and streams erase/draw sweeps to the VGA plotter.
// Optional bullet spawning is enabled by defining PLAYER_FIRE_EN.
module player_sprite_ctrl #(
    parameter int          SPR_W    = 5,
    parameter int          SPR_H    = 4,
    parameter int          X_MAX    = 159,
    parameter int          START_X  = 78,
    parameter int          START_Y  = 100,
    parameter int          STEP     = 1,
    parameter logic [2:0]  COLOUR   = 3'b111,
    parameter int          COOLDOWN = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       left,
    input  logic       right,
    input  logic       got_hit,
    input  logic       plot_ready,
    output logic       plot,
    output logic [7:0] x_pos,
    output logic [6:0] y_pos,
    output logic [2:0] colour,
    output logic       busy,
    output logic       alive,
    input  logic       fire,
    output logic       shot_req,
    output logic [7:0] shot_x,
    output logic [6:0] shot_y
);

    typedef enum logic [2:0] {DRAW, IDLE, ERASE, UPDATE, DEAD} state_t;

    localparam logic [3:0] LAST_COL = 4'(SPR_W - 1);
    localparam logic [3:0] LAST_ROW = 4'(SPR_H - 1);
    localparam logic [7:0] STEP8    = 8'(STEP);

    state_t     state;
    logic [7:0] x_reg;
    logic [3:0] col;
    logic [3:0] row;
    logic       kill;
    logic       dir_left;
    logic       hit_pend;

    logic [8:0] right_reach;
    logic       can_left;
    logic       can_right;

    // Legality is evaluated in 9 bits so the right-edge test cannot wrap.
    assign right_reach = {1'b0, x_reg} + 9'(STEP + SPR_W - 1);
    assign can_left    = (x_reg >= STEP8);
    assign can_right   = (right_reach <= 9'(X_MAX));

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state    <= DRAW;
            x_reg    <= 8'(START_X);
            col      <= '0;
            row      <= '0;
            kill     <= 1'b0;
            dir_left <= 1'b0;
            hit_pend <= 1'b0;
            plot     <= 1'b0;
            x_pos    <= '0;
            y_pos    <= '0;
            colour   <= '0;
            busy     <= 1'b0;
            alive    <= 1'b1;
        end else begin
            case (state)
                DRAW, ERASE: begin
                    busy <= 1'b1;
                    if (got_hit)
                        hit_pend <= 1'b1;
                    if (!plot) begin
                        plot   <= 1'b1;
                        x_pos  <= x_reg;
                        y_pos  <= 7'(START_Y);
                        colour <= (state == DRAW) ? COLOUR : 3'b000;
                    end else if (plot_ready) begin
                        // Address only advances on an accepted pixel, so a stall holds it stable.
                        if (col == LAST_COL) begin
                            col <= '0;
                            if (row == LAST_ROW) begin
                                row  <= '0;
                                plot <= 1'b0;
                                if (state == DRAW) begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end else if (kill) begin
                                    state <= DEAD;
                                    busy  <= 1'b0;
                                end else begin
                                    state <= UPDATE;
                                end
                            end else begin
                                row   <= row + 4'd1;
                                x_pos <= x_reg;
                                y_pos <= y_pos + 7'd1;
                            end
                        end else begin
                            col   <= col + 4'd1;
                            x_pos <= x_pos + 8'd1;
                        end
                    end
                end
                IDLE: begin
                    if (hit_pend || got_hit) begin
                        state    <= ERASE;
                        kill     <= 1'b1;
                        alive    <= 1'b0;
                        hit_pend <= 1'b0;
                        busy     <= 1'b1;
                    end else if (tick && (left ^ right) && (left ? can_left : can_right)) begin
                        state    <= ERASE;
                        kill     <= 1'b0;
                        dir_left <= left;
                        busy     <= 1'b1;
                    end
                end
                UPDATE: begin
                    if (got_hit)
                        hit_pend <= 1'b1;
                    x_reg <= dir_left ? (x_reg - STEP8) : (x_reg + STEP8);
                    state <= DRAW;
                    busy  <= 1'b1;
                end
                DEAD: begin
                    plot <= 1'b0;
                    busy <= 1'b0;
                end
                default: begin
                    state <= DEAD;
                    plot  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLAYER_FIRE_EN
    logic [7:0] cooldown;

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            cooldown <= '0;
            shot_req <= 1'b0;
            shot_x   <= '0;
            shot_y   <= '0;
        end else begin
            shot_req <= 1'b0;
            if (tick) begin
                if (fire && cooldown == 8'd0 && alive && state != DEAD) begin
                    shot_req <= 1'b1;
                    cooldown <= 8'(COOLDOWN);
                    shot_x   <= x_reg + 8'(SPR_W / 2);
                    shot_y   <= 7'(START_Y - 1);
                end else if (cooldown != 8'd0) begin
                    cooldown <= cooldown - 8'd1;
                end
            end
        end
    end
`else
    logic unused_fire;
    assign unused_fire = fire ^ (COOLDOWN != 0);
    assign shot_req    = 1'b0;
    assign shot_x      = '0;
    assign shot_y      = '0;
`endif

endmodule

// File: tb/tb_player_sprite_ctrl.sv
// Directed self-checking bench for player_sprite_ctrl with default parameters.
module tb_player_sprite_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick, left, right, got_hit, plot_ready, fire;
    logic       plot, busy, alive, shot_req;
    logic [7:0] x_pos, shot_x;
    logic [6:0] y_pos, shot_y;
    logic [2:0] colour;

    int checks   = 0;
    int failures = 0;

    player_sprite_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .left       (left),
        .right      (right),
        .got_hit    (got_hit),
        .plot_ready (plot_ready),
        .plot       (plot),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .colour     (colour),
        .busy       (busy),
        .alive      (alive),
        .fire       (fire),
        .shot_req   (shot_req),
        .shot_x     (shot_x),
        .shot_y     (shot_y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Collects one 5x4 sweep, checking every accepted pixel and stability while stalled.
    task automatic sweep(input string tag, input logic [2:0] col_e, input logic [7:0] xb,
                         input bit bp, input int hit_at);
        int          n = 0;
        int          cyc = 0;
        bit          tog = 1'b0;
        bit          stalled = 1'b0;
        bit          hit_done = 1'b0;
        logic [17:0] saved = '0;
        logic        pr;
        while (n < 20 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            got_hit = 1'b0;
            if (n == hit_at && !hit_done) begin
                got_hit  = 1'b1;
                hit_done = 1'b1;
            end
            if (stalled) begin
                chk({tag, "_stall_plot"}, 32'(plot), 32'd1);
                chk({tag, "_stall_hold"}, 32'({x_pos, y_pos, colour}), 32'(saved));
            end
            pr = bp ? tog : 1'b1;
            tog = ~tog;
            plot_ready = pr;
            if (plot === 1'b1 && pr) begin
                chk({tag, "_x"}, 32'(x_pos), 32'(xb + 8'(n % 5)));
                chk({tag, "_y"}, 32'(y_pos), 32'(100 + n / 5));
                chk({tag, "_colour"}, 32'(colour), 32'(col_e));
                n++;
                stalled = 1'b0;
            end else if (plot === 1'b1) begin
                stalled = 1'b1;
                saved   = {x_pos, y_pos, colour};
            end else begin
                stalled = 1'b0;
            end
        end
        got_hit = 1'b0;
        chk({tag, "_count"}, 32'(n), 32'd20);
        @(negedge clk);
        plot_ready = 1'b1;
        chk({tag, "_plot_end"}, 32'(plot), 32'd0);
    endtask

    task automatic tick_move(input logic l, input logic r);
        @(negedge clk);
        left  = l;
        right = r;
        tick  = 1'b1;
        @(negedge clk);
        tick  = 1'b0;
        left  = 1'b0;
        right = 1'b0;
    endtask

    task automatic no_plot(input string tag, input int cycles);
        bit seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (plot !== 1'b0) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1;
        tick = 1'b0; left = 1'b0; right = 1'b0; got_hit = 1'b0; fire = 1'b0;
        plot_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_x", 32'(x_pos), 32'd0);
        chk("rst_y", 32'(y_pos), 32'd0);
        chk("rst_colour", 32'(colour), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alive", 32'(alive), 32'd1);
        chk("rst_shot", 32'(shot_req), 32'd0);
        reset_n = 1'b0;

        // T1: initial draw at START_X
        sweep("t1_draw", 3'b111, 8'd78, 1'b0, -1);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_alive", 32'(alive), 32'd1);

        // T2: one step right
        tick_move(1'b0, 1'b1);
        sweep("t2_erase", 3'b000, 8'd78, 1'b0, -1);
        sweep("t2_draw", 3'b111, 8'd79, 1'b0, -1);
        chk("t2_busy", 32'(busy), 32'd0);

        // T3: walk to the left edge, then to the right limit
        for (int i = 0; i < 79; i++) begin
            tick_move(1'b1, 1'b0);
            sweep("t3_lerase", 3'b000, 8'(79 - i), 1'b0, -1);
            sweep("t3_ldraw", 3'b111, 8'(78 - i), 1'b0, -1);
        end
        tick_move(1'b1, 1'b0);
        no_plot("t3_left_edge", 12);
        tick_move(1'b1, 1'b1);
        no_plot("t3_both", 12);
        for (int i = 0; i < 155; i++) begin
            tick_move(1'b0, 1'b1);
            sweep("t3_rerase", 3'b000, 8'(i), 1'b0, -1);
            sweep("t3_rdraw", 3'b111, 8'(i + 1), 1'b0, -1);
        end
        tick_move(1'b0, 1'b1);
        no_plot("t3_right_edge", 12);
        chk("t3_busy", 32'(busy), 32'd0);

        // T4: backpressure on both sweeps of a left move
        tick_move(1'b1, 1'b0);
        sweep("t4_erase", 3'b000, 8'd155, 1'b1, -1);
        sweep("t4_draw", 3'b111, 8'd154, 1'b1, -1);

`ifdef PLAYER_FIRE_EN
        // T6: fire held; pulses on ticks 1 and 10 at x_reg=154
        fire = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("t6_pulse_width", 32'(shot_req), 32'd0);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            chk("t6_shot_req", 32'(shot_req), (k == 1 || k == 10) ? 32'd1 : 32'd0);
            if (k == 1 || k == 10) begin
                chk("t6_shot_x", 32'(shot_x), 32'd156);
                chk("t6_shot_y", 32'(shot_y), 32'd99);
            end
        end
        fire = 1'b0;
        no_plot("t6_no_move", 4);
`endif

        // T5: hit mid-draw, draw completes, kill erase, then dead
        tick_move(1'b1, 1'b0);
        sweep("t5_erase", 3'b000, 8'd154, 1'b0, -1);
        sweep("t5_draw", 3'b111, 8'd153, 1'b0, 7);
        chk("t5_alive_pre", 32'(alive), 32'd1);
        sweep("t5_kill", 3'b000, 8'd153, 1'b0, -1);
        chk("t5_alive", 32'(alive), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        tick_move(1'b1, 1'b0);
        no_plot("t5_dead_left", 12);
        tick_move(1'b0, 1'b1);
        no_plot("t5_dead_right", 12);
        chk("t5_alive_stay", 32'(alive), 32'd0);
`ifdef PLAYER_FIRE_EN
        begin
            bit shot_seen = 1'b0;
            fire = 1'b1;
            repeat (12) begin
                @(negedge clk); tick = 1'b1;
                @(negedge clk); tick = 1'b0;
                if (shot_req !== 1'b0) shot_seen = 1'b1;
            end
            fire = 1'b0;
            chk("t6_dead_noshot", 32'(shot_seen), 32'd0);
        end
`endif

        // Reset from DEAD, abort a sweep with reset, restart cleanly at START_X
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("t7_rst_alive", 32'(alive), 32'd1);
        reset_n = 1'b0;
        repeat (8) @(negedge clk);
        chk("t7_mid_plot", 32'(plot), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);
        chk("t7_abort_plot", 32'(plot), 32'd0);
        reset_n = 1'b0;
        sweep("t7_draw", 3'b111, 8'd78, 1'b0, -1);
        chk("t7_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
